// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, RV32 opcode/funct constants, immediate helpers and the issue-buffer entry
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_XOR     = 4'b0001,
        ALU_SLL     = 4'b0010,
        ALU_ADD     = 4'b0011,
        ALU_SUB     = 4'b0100,
        ALU_MUL     = 4'b0101,
        ALU_ADDI    = 4'b0110,
        ALU_SRAI    = 4'b0111,
        ALU_ILLEGAL = 4'b1111
    } alu_ctrl_e;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MUL    = 7'b0000001;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_W      = 3'b010;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    typedef struct packed {
        alu_ctrl_e   ctrl;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        illegal;
    } entry_t;
    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction
    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction
endpackage

// File: rtl/alu_issue_buffer_if.sv
// alu_issue_buffer_if: upstream issue handshake + register operands in, decoded ALU entry out
// slave: the buffer's view; master: the driver/monitor's view
interface alu_issue_buffer_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] inst_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic [3:0]  ALUCtrl_o;
    logic [31:0] imm_o;
    logic [4:0]  rd_o;
    logic        reg_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        branch_o;
    logic        illegal_o;
    modport slave (
        input  in_valid_i, inst_i, rs1_data_i, rs2_data_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, data1_o, data2_o, ALUCtrl_o, imm_o, rd_o,
               reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o
    );
    modport master (
        output in_valid_i, inst_i, rs1_data_i, rs2_data_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, data1_o, data2_o, ALUCtrl_o, imm_o, rd_o,
               reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational RV32 decode of the supported subset
// in: inst_i; out: alu_ctrl_o, imm_o, reg_write/mem_read/mem_write/branch, use_rs2_o (data2 from rs2), illegal_o
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0] inst_i,
    output alu_ctrl_e   alu_ctrl_o,
    output logic [31:0] imm_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        branch_o,
    output logic        use_rs2_o,
    output logic        illegal_o
);
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_raw;
    logic        unused_rs1;
    assign opcode     = inst_i[6:0];
    assign funct3     = inst_i[14:12];
    assign funct7     = inst_i[31:25];
    assign unused_rs1 = ^inst_i[19:15];
    always_comb begin
        alu_ctrl_o = ALU_ILLEGAL;
        imm_raw    = '0;
        case (opcode)
            OP_R: case ({funct7, funct3})
                {F7_BASE, F3_AND}: alu_ctrl_o = ALU_AND;
                {F7_BASE, F3_XOR}: alu_ctrl_o = ALU_XOR;
                {F7_BASE, F3_SLL}: alu_ctrl_o = ALU_SLL;
                {F7_BASE, F3_ADD}: alu_ctrl_o = ALU_ADD;
                {F7_ALT,  F3_ADD}: alu_ctrl_o = ALU_SUB;
                {F7_MUL,  F3_ADD}: alu_ctrl_o = ALU_MUL;
                default:           alu_ctrl_o = ALU_ILLEGAL;
            endcase
            OP_I: begin
                alu_ctrl_o = funct3 == F3_ADD ? ALU_ADDI :
                             (funct3 == F3_SR && funct7 == F7_ALT) ? ALU_SRAI : ALU_ILLEGAL;
                imm_raw    = imm_i(inst_i);
            end
            OP_LOAD: begin
                alu_ctrl_o = funct3 == F3_W ? ALU_ADD : ALU_ILLEGAL;
                imm_raw    = imm_i(inst_i);
            end
            OP_STORE: begin
                alu_ctrl_o = funct3 == F3_W ? ALU_ADD : ALU_ILLEGAL;
                imm_raw    = imm_s(inst_i);
            end
            OP_BRANCH: begin
                alu_ctrl_o = funct3 == F3_BEQ ? ALU_SUB : ALU_ILLEGAL;
                imm_raw    = imm_b(inst_i);
            end
            default: alu_ctrl_o = ALU_ILLEGAL;
        endcase
    end
    assign illegal_o   = alu_ctrl_o == ALU_ILLEGAL;
    assign imm_o       = illegal_o ? 32'b0 : imm_raw;
    assign reg_write_o = !illegal_o && (opcode == OP_R || opcode == OP_I || opcode == OP_LOAD);
    assign mem_read_o  = !illegal_o && opcode == OP_LOAD;
    assign mem_write_o = !illegal_o && opcode == OP_STORE;
    assign branch_o    = !illegal_o && opcode == OP_BRANCH;
    assign use_rs2_o   = !illegal_o && (opcode == OP_R || opcode == OP_BRANCH);
endmodule

// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer: 2-entry FIFO of pre-decoded ALU entries between issue and EX
// ports: clk_i, rst_i (sync, active-high); bus (slave) carries the in/out handshakes, operands and decoded outputs
module alu_issue_buffer
    import alu_pkg::*;
(
    input logic               clk_i,
    input logic               rst_i,
    alu_issue_buffer_if.slave bus
);
    alu_ctrl_e   dec_ctrl;
    logic [31:0] dec_imm;
    logic        dec_rw, dec_mr, dec_mw, dec_br, dec_rs2, dec_ill;
    entry_t      new_entry;
    entry_t      out_entry;
    entry_t      mem_q [2];
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, rd_ptr_q;
    logic        push, pop;
    alu_ctrl_decode u_dec (
        .inst_i      (bus.inst_i),
        .alu_ctrl_o  (dec_ctrl),
        .imm_o       (dec_imm),
        .reg_write_o (dec_rw),
        .mem_read_o  (dec_mr),
        .mem_write_o (dec_mw),
        .branch_o    (dec_br),
        .use_rs2_o   (dec_rs2),
        .illegal_o   (dec_ill)
    );
    // srai's operand is the raw shamt, not the sign-extended I-immediate reported on imm_o
    assign new_entry = '{
        ctrl:      dec_ctrl,
        data1:     bus.rs1_data_i,
        data2:     dec_ill ? 32'b0 : dec_rs2 ? bus.rs2_data_i :
                   dec_ctrl == ALU_SRAI ? {27'b0, bus.inst_i[24:20]} : dec_imm,
        imm:       dec_imm,
        rd:        dec_rw ? bus.inst_i[11:7] : 5'b0,
        reg_write: dec_rw,
        mem_read:  dec_mr,
        mem_write: dec_mw,
        branch:    dec_br,
        illegal:   dec_ill
    };
    assign bus.in_ready_o  = count_q != 2'd2 && !rst_i;
    assign bus.out_valid_o = count_q != 2'd0;
    assign push    = bus.in_valid_i && bus.in_ready_o;
    assign pop     = bus.out_valid_o && bus.out_ready_i;
    assign count_d = count_q + {1'b0, push} - {1'b0, pop};
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= new_entry;
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            count_q  <= count_d;
        end
    end
    assign out_entry       = bus.out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign bus.ALUCtrl_o   = out_entry.ctrl;
    assign bus.data1_o     = out_entry.data1;
    assign bus.data2_o     = out_entry.data2;
    assign bus.imm_o       = out_entry.imm;
    assign bus.rd_o        = out_entry.rd;
    assign bus.reg_write_o = out_entry.reg_write;
    assign bus.mem_read_o  = out_entry.mem_read;
    assign bus.mem_write_o = out_entry.mem_write;
    assign bus.branch_o    = out_entry.branch;
    assign bus.illegal_o   = out_entry.illegal;
endmodule

// File: tb/tb_alu_issue_buffer.sv
// tb_alu_issue_buffer: directed + random stimulus against a queue-based mnemonic-level reference model
module tb_alu_issue_buffer;
    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    alu_issue_buffer_if bus ();
    alu_issue_buffer dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    initial forever #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        string       m;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] ii, si, bi;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        ii = {{20{w[31]}}, w[31:20]};
        si = {{20{w[31]}}, w[31:25], w[11:7]};
        bi = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        m  = "";
        e  = '0;
        e.ctrl = 4'hF;
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) begin m = "r"; e.ctrl = 4'h0; end
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd4) begin m = "r"; e.ctrl = 4'h1; end
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd1) begin m = "r"; e.ctrl = 4'h2; end
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin m = "r"; e.ctrl = 4'h3; end
        if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin m = "r"; e.ctrl = 4'h4; end
        if (op == 7'h33 && f7 == 7'h01 && f3 == 3'd0) begin m = "r"; e.ctrl = 4'h5; end
        if (op == 7'h13 && f3 == 3'd0) begin m = "addi"; e.ctrl = 4'h6; end
        if (op == 7'h13 && f3 == 3'd5 && f7 == 7'h20) begin m = "srai"; e.ctrl = 4'h7; end
        if (op == 7'h03 && f3 == 3'd2) begin m = "lw"; e.ctrl = 4'h3; end
        if (op == 7'h23 && f3 == 3'd2) begin m = "sw"; e.ctrl = 4'h3; end
        if (op == 7'h63 && f3 == 3'd0) begin m = "beq"; e.ctrl = 4'h4; end
        e.d1 = a;
        case (m)
            "r":    begin e.d2 = b; e.rd = w[11:7]; e.rw = 1'b1; end
            "addi": begin e.d2 = ii; e.imm = ii; e.rd = w[11:7]; e.rw = 1'b1; end
            "lw":   begin e.d2 = ii; e.imm = ii; e.rd = w[11:7]; e.rw = 1'b1; e.mr = 1'b1; end
            "srai": begin e.d2 = {27'b0, w[24:20]}; e.imm = ii; e.rd = w[11:7]; e.rw = 1'b1; end
            "sw":   begin e.d2 = si; e.imm = si; e.mw = 1'b1; end
            "beq":  begin e.d2 = b; e.imm = bi; e.br = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction
    function automatic logic [31:0] gen_inst();
        logic [6:0]  ops [6];
        logic [6:0]  f7s [3];
        logic [31:0] w;
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h33};
        f7s = '{7'h00, 7'h20, 7'h01};
        w = $urandom();
        k = $urandom_range(0, 7);
        if (k <= 5) w[6:0] = ops[k];
        if (k == 0 || k == 5) w[31:25] = f7s[$urandom_range(0, 2)];
        if (k == 0 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
        if (k == 1 && $urandom_range(0, 1) == 1) w[14:12] = $urandom_range(0, 1) == 1 ? 3'd0 : 3'd5;
        if (k == 1 && w[14:12] == 3'd5 && $urandom_range(0, 2) != 0) w[31:25] = 7'h20;
        if ((k == 2 || k == 3) && $urandom_range(0, 3) != 0) w[14:12] = 3'd2;
        if (k == 4 && $urandom_range(0, 3) != 0) w[14:12] = 3'd0;
        return w;
    endfunction
    // one clock: drive inputs at negedge, compare against the model, then advance the model at posedge
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                         input logic rdy, input logic fl, input logic rs);
        exp_t h, e;
        logic push, pop;
        bus.in_valid_i  = v;
        bus.inst_i      = inst;
        bus.rs1_data_i  = r1;
        bus.rs2_data_i  = r2;
        bus.out_ready_i = rdy;
        bus.flush_i     = fl;
        rst             = rs;
        #1;
        h = q.size() != 0 ? q[0] : '0;
        check("out_valid", {31'b0, bus.out_valid_o}, {31'b0, q.size() != 0});
        check("in_ready", {31'b0, bus.in_ready_o}, {31'b0, q.size() < 2 && !rs});
        check("ctrl", {28'b0, bus.ALUCtrl_o}, {28'b0, h.ctrl});
        check("data1", bus.data1_o, h.d1);
        check("data2", bus.data2_o, h.d2);
        check("imm", bus.imm_o, h.imm);
        check("rd", {27'b0, bus.rd_o}, {27'b0, h.rd});
        check("flags", {27'b0, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.branch_o, bus.illegal_o},
              {27'b0, h.rw, h.mr, h.mw, h.br, h.ill});
        push = v && !rs && q.size() < 2;
        pop  = q.size() != 0 && rdy;
        e    = ref_decode(inst, r1, r2);
        @(posedge clk);
        if (rs || fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
        end
        @(negedge clk);
    endtask
    initial begin
        bus.in_valid_i  = 1'b0;
        bus.inst_i      = '0;
        bus.rs1_data_i  = '0;
        bus.rs2_data_i  = '0;
        bus.out_ready_i = 1'b0;
        bus.flush_i     = 1'b0;
        rst             = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 32'h002081B3, 32'd5, 32'd7, 0, 0, 0);
        check("add_ctrl", {28'b0, bus.ALUCtrl_o}, 32'h3);
        check("add_d1", bus.data1_o, 32'd5);
        check("add_d2", bus.data2_o, 32'd7);
        check("add_rd", {27'b0, bus.rd_o}, 32'd3);
        check("add_rw", {31'b0, bus.reg_write_o}, 32'd1);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 32'h40335293, 32'hFFFFFFF0, 32'h1234, 0, 0, 0);
        check("srai_ctrl", {28'b0, bus.ALUCtrl_o}, 32'h7);
        check("srai_d1", bus.data1_o, 32'hFFFFFFF0);
        check("srai_d2", bus.data2_o, 32'h3);
        check("srai_rd", {27'b0, bus.rd_o}, 32'd5);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 32'hFE20AE23, 32'h100, 32'h55, 0, 0, 0);
        check("sw_ctrl", {28'b0, bus.ALUCtrl_o}, 32'h3);
        check("sw_d2", bus.data2_o, 32'hFFFFFFFC);
        check("sw_mw", {31'b0, bus.mem_write_o}, 32'd1);
        check("sw_rw", {31'b0, bus.reg_write_o}, 32'd0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 32'h00100093, 32'd1, 32'd2, 0, 0, 0);
        cycle(1, 32'h0020C233, 32'd3, 32'd4, 0, 0, 0);
        check("full_ready", {31'b0, bus.in_ready_o}, 32'd0);
        cycle(1, 32'h00208463, 32'd5, 32'd6, 0, 0, 0);
        cycle(1, 32'h00208463, 32'd5, 32'd6, 1, 0, 0);
        cycle(1, 32'h00208463, 32'd5, 32'd6, 1, 0, 0);
        check("third_ctrl", {28'b0, bus.ALUCtrl_o}, 32'h4);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 32'h00100093, 32'd1, 32'd2, 0, 0, 0);
        cycle(1, 32'h0020C233, 32'd3, 32'd4, 0, 0, 0);
        cycle(1, 32'h00208463, 32'd5, 32'd6, 1, 1, 0);
        check("flush_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("flush_ready", {31'b0, bus.in_ready_o}, 32'd1);
        repeat (3) cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 32'h00000000, 32'd9, 32'd9, 0, 0, 0);
        check("ill_flag", {31'b0, bus.illegal_o}, 32'd1);
        check("ill_ctrl", {28'b0, bus.ALUCtrl_o}, 32'hF);
        check("ill_rw", {31'b0, bus.reg_write_o}, 32'd0);
        check("ill_d2", bus.data2_o, 32'd0);
        cycle(1, 32'h00100093, 32'd1, 32'd2, 0, 0, 0);
        cycle(1, 32'h0020C233, 32'd3, 32'd4, 1, 0, 1);
        check("rst_valid", {31'b0, bus.out_valid_o}, 32'd0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 9) < 7, gen_inst(), $urandom(), $urandom(),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
